// File: rtl/ia_operand_fetch.sv
// ia_operand_fetch
//   Operand fetch stage in front of the u32 adder. Takes one decoded adder
//   instruction per cycle and resolves each operand (immediate or register)
//   to a 32-bit value. Register values come from the register file read
//   ports, or are forwarded from the same-cycle writeback. The stage also
//   evaluates the single-flag condition and holds back instructions that
//   touch a register with a write still pending (busy scoreboard).
//   The result is registered into a valid/ready slot for the adder.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   instruction handshake from decode
//   in_op1_imm, in_op1    operand 1: immediate flag + value/register address
//   in_op2_imm, in_op2    operand 2: same
//   in_dest, in_fsel      destination register, condition flag selector
//   flags                 current condition flags
//   rf_raddrN / rf_rdataN combinational register file read ports
//   wb_valid/addr/data    writeback port (clears busy, forwarding source)
//   out_valid / out_ready handshake to the adder
//   out_a, out_b          resolved operands
//   out_dest, out_cond    destination and condition result
//   stall_cnt             saturating count of hazard-stall cycles
module ia_operand_fetch #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int ADDR_W    = 4,
  parameter int NUM_FLAGS = 8,
  parameter int FSEL_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_op1_imm,
  input  logic [DATA_W-1:0]    in_op1,
  input  logic                 in_op2_imm,
  input  logic [DATA_W-1:0]    in_op2,
  input  logic [ADDR_W-1:0]    in_dest,
  input  logic [FSEL_W-1:0]    in_fsel,
  input  logic [NUM_FLAGS-1:0] flags,
  output logic [ADDR_W-1:0]    rf_raddr1,
  input  logic [DATA_W-1:0]    rf_rdata1,
  output logic [ADDR_W-1:0]    rf_raddr2,
  input  logic [DATA_W-1:0]    rf_rdata2,
  input  logic                 wb_valid,
  input  logic [ADDR_W-1:0]    wb_addr,
  input  logic [DATA_W-1:0]    wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_a,
  output logic [DATA_W-1:0]    out_b,
  output logic [ADDR_W-1:0]    out_dest,
  output logic                 out_cond,
  output logic [15:0]          stall_cnt
);

  // Immediate wins, then the in-flight writeback, then the register file.
  function automatic logic [DATA_W-1:0] sel_operand(
    input logic              imm,
    input logic [DATA_W-1:0] op,
    input logic              hit,
    input logic [DATA_W-1:0] fwd,
    input logic [DATA_W-1:0] rdata
  );
    logic [DATA_W-1:0] v;
    if (imm)      v = op;
    else if (hit) v = fwd;
    else          v = rdata;
    return v;
  endfunction

  // All-ones selector means "always"; selectors beyond the flag count are
  // never true.
  function automatic logic eval_cond(
    input logic [FSEL_W-1:0]    fsel,
    input logic [NUM_FLAGS-1:0] f
  );
    logic c;
    c = (fsel == {FSEL_W{1'b1}});
    for (int i = 0; i < NUM_FLAGS; i++) begin
      if (fsel == FSEL_W'(i) && f[i]) c = 1'b1;
    end
    return c;
  endfunction

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                r_vld_p1;
  logic [DATA_W-1:0]   r_a_p1;
  logic [DATA_W-1:0]   r_b_p1;
  logic [ADDR_W-1:0]   r_dest_p1;
  logic                r_cond_p1;
  logic [15:0]         r_stall_cnt;

  logic [ADDR_W-1:0]   w_raddr1_p0;
  logic [ADDR_W-1:0]   w_raddr2_p0;
  logic                w_hit1_p0;
  logic                w_hit2_p0;
  logic                w_hitd_p0;
  logic                w_hazard_p0;
  logic                w_accept_p0;
  logic                w_cond_p0;
  logic [DATA_W-1:0]   w_a_p0;
  logic [DATA_W-1:0]   w_b_p0;

  // ---- stage p0: resolve operands, hazard check, condition ----
  assign w_raddr1_p0 = in_op1[ADDR_W-1:0];
  assign w_raddr2_p0 = in_op2[ADDR_W-1:0];
  assign rf_raddr1   = w_raddr1_p0;
  assign rf_raddr2   = w_raddr2_p0;

  assign w_hit1_p0 = wb_valid && (wb_addr == w_raddr1_p0);
  assign w_hit2_p0 = wb_valid && (wb_addr == w_raddr2_p0);
  assign w_hitd_p0 = wb_valid && (wb_addr == in_dest);

  // A register whose pending write lands this very cycle is not a hazard:
  // the value is forwarded and its busy bit clears at this edge.
  assign w_hazard_p0 = in_valid &&
                       ((!in_op1_imm && r_busy[w_raddr1_p0] && !w_hit1_p0) ||
                        (!in_op2_imm && r_busy[w_raddr2_p0] && !w_hit2_p0) ||
                        (r_busy[in_dest] && !w_hitd_p0));

  assign in_ready    = !rst && !w_hazard_p0 && (!r_vld_p1 || out_ready);
  assign w_accept_p0 = in_valid && in_ready;

  assign w_cond_p0 = eval_cond(in_fsel, flags);
  assign w_a_p0    = sel_operand(in_op1_imm, in_op1, w_hit1_p0, wb_data, rf_rdata1);
  assign w_b_p0    = sel_operand(in_op2_imm, in_op2, w_hit2_p0, wb_data, rf_rdata2);

  // Clear first, then set, so a same-address set in the same cycle wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid) w_busy_nxt[wb_addr] = 1'b0;
    if (w_accept_p0 && w_cond_p0) w_busy_nxt[in_dest] = 1'b1;
  end

  // ---- stage p1: output slot to the adder ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1    <= 1'b0;
      r_a_p1      <= '0;
      r_b_p1      <= '0;
      r_dest_p1   <= '0;
      r_cond_p1   <= 1'b0;
      r_busy      <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_accept_p0) begin
        r_vld_p1  <= 1'b1;
        r_a_p1    <= w_a_p0;
        r_b_p1    <= w_b_p0;
        r_dest_p1 <= in_dest;
        r_cond_p1 <= w_cond_p0;
      end else if (out_ready) begin
        r_vld_p1  <= 1'b0;
      end
      r_busy <= w_busy_nxt;
      if (w_hazard_p0 && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign out_valid = r_vld_p1;
  assign out_a     = r_a_p1;
  assign out_b     = r_b_p1;
  assign out_dest  = r_dest_p1;
  assign out_cond  = r_cond_p1;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_ia_operand_fetch.sv
module tb_ia_operand_fetch;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_op1_imm;
  logic [31:0] in_op1;
  logic        in_op2_imm;
  logic [31:0] in_op2;
  logic [3:0]  in_dest;
  logic [3:0]  in_fsel;
  logic [7:0]  flags;
  logic [3:0]  rf_raddr1;
  logic [31:0] rf_rdata1;
  logic [3:0]  rf_raddr2;
  logic [31:0] rf_rdata2;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_dest;
  logic        out_cond;
  logic [15:0] stall_cnt;

  ia_operand_fetch #(
    .DATA_W(32), .NUM_REGS(16), .ADDR_W(4), .NUM_FLAGS(8), .FSEL_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1_imm(in_op1_imm), .in_op1(in_op1),
    .in_op2_imm(in_op2_imm), .in_op2(in_op2),
    .in_dest(in_dest), .in_fsel(in_fsel), .flags(flags),
    .rf_raddr1(rf_raddr1), .rf_rdata1(rf_rdata1),
    .rf_raddr2(rf_raddr2), .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_dest(out_dest), .out_cond(out_cond),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Register file environment: combinational read, written by writeback.
  logic [31:0] rf [16];
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [15:0] m_busy  = '0;
  logic        m_ov    = 1'b0;
  logic [31:0] m_a     = '0;
  logic [31:0] m_b     = '0;
  logic [3:0]  m_dest  = '0;
  logic        m_cond  = 1'b0;
  int          m_stall = 0;

  typedef struct packed {
    logic        i1;
    logic [31:0] o1;
    logic        i2;
    logic [31:0] o2;
    logic [3:0]  dest;
    logic [3:0]  fsel;
    logic [7:0]  flg;
    logic        wv;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        e_rdy;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        e_cond;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic i1, input logic [31:0] o1,
                       input logic i2, input logic [31:0] o2, input logic [3:0] d,
                       input logic [3:0] fs, input logic [7:0] fl, input logic wv,
                       input logic [3:0] wa, input logic [31:0] wd, input logic ordy);
    in_valid = v;  in_op1_imm = i1; in_op1 = o1; in_op2_imm = i2; in_op2 = o2;
    in_dest = d;   in_fsel = fs;    flags = fl;  wb_valid = wv;   wb_addr = wa;
    wb_data = wd;  out_ready = ordy;
  endtask

  // One clock: predict from the rules, check ready before the edge and
  // the registered outputs after it.
  task automatic step();
    logic [3:0]  a1, a2;
    logic        hit1, hit2, hitd, haz, rdy, acc, cnd;
    logic [31:0] va, vb;
    #1;
    a1   = 4'(in_op1 % 32'd16);
    a2   = 4'(in_op2 % 32'd16);
    hit1 = wb_valid && (wb_addr == a1);
    hit2 = wb_valid && (wb_addr == a2);
    hitd = wb_valid && (wb_addr == in_dest);
    haz  = in_valid && ((!in_op1_imm && m_busy[a1] && !hit1) ||
                        (!in_op2_imm && m_busy[a2] && !hit2) ||
                        (m_busy[in_dest] && !hitd));
    rdy  = !rst && !haz && (!m_ov || out_ready);
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    chk("rf_raddr2", {28'd0, rf_raddr2}, {28'd0, a2});
    acc = in_valid && rdy;
    cnd = (in_fsel == 4'hF) || ((in_fsel < 4'd8) && flags[in_fsel[2:0]]);
    va  = in_op1_imm ? in_op1 : (hit1 ? wb_data : rf[a1]);
    vb  = in_op2_imm ? in_op2 : (hit2 ? wb_data : rf[a2]);
    if (rst) begin
      m_ov = 0; m_a = 0; m_b = 0; m_dest = 0; m_cond = 0; m_stall = 0; m_busy = 0;
    end else begin
      if (haz && m_stall < 65535) m_stall++;
      if (acc) begin
        m_ov = 1; m_a = va; m_b = vb; m_dest = in_dest; m_cond = cnd;
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (wb_valid) m_busy[wb_addr] = 1'b0;
      if (acc && cnd) m_busy[in_dest] = 1'b1;
    end
    @(posedge clk);
    #1;
    if (wb_valid) rf[wb_addr] = wb_data;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("out_a", out_a, m_a);
    chk("out_b", out_b, m_b);
    chk("out_dest", {28'd0, out_dest}, {28'd0, m_dest});
    chk("out_cond", {31'd0, out_cond}, {31'd0, m_cond});
    chk("stall_cnt", {16'd0, stall_cnt}, 32'(m_stall));
    chk("busy", {16'd0, dut.r_busy}, {16'd0, m_busy});
  endtask

  initial begin
    clk = 0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h1000_0000 + 32'(i);
    rf[2] = 32'd100;
    rf[3] = 32'h333;
    rf[4] = 32'hFFFF_FFFF;

    //             i1  o1      i2  o2      dest fsel  flg    wv wa  wd     rdy a             b             cond
    tbl[0] = '{1'b1, 32'd5,  1'b1, 32'd7,  4'd3, 4'hF, 8'h00, 1'b0, 4'd0, 32'd0,  1'b1, 32'd5,        32'd7,        1'b1};
    tbl[1] = '{1'b0, 32'd2,  1'b0, 32'h14, 4'd6, 4'hF, 8'h00, 1'b0, 4'd0, 32'd0,  1'b1, 32'd100,      32'hFFFF_FFFF, 1'b1};
    tbl[2] = '{1'b1, 32'd1,  1'b1, 32'd2,  4'd7, 4'd2, 8'h00, 1'b0, 4'd0, 32'd0,  1'b1, 32'd1,        32'd2,        1'b0};
    tbl[3] = '{1'b1, 32'd3,  1'b1, 32'd4,  4'd8, 4'd2, 8'h04, 1'b0, 4'd0, 32'd0,  1'b1, 32'd3,        32'd4,        1'b1};
    tbl[4] = '{1'b1, 32'd5,  1'b1, 32'd6,  4'd9, 4'd9, 8'hFF, 1'b0, 4'd0, 32'd0,  1'b1, 32'd5,        32'd6,        1'b0};
    tbl[5] = '{1'b1, 32'd7,  1'b1, 32'd8,  4'd9, 4'd8, 8'hFF, 1'b0, 4'd0, 32'd0,  1'b1, 32'd7,        32'd8,        1'b0};
    tbl[6] = '{1'b1, 32'd9,  1'b1, 32'd10, 4'd10, 4'd7, 8'h80, 1'b0, 4'd0, 32'd0, 1'b1, 32'd9,        32'd10,       1'b1};
    tbl[7] = '{1'b0, 32'd3,  1'b1, 32'd9,  4'd11, 4'hF, 8'h00, 1'b1, 4'd3, 32'd42, 1'b1, 32'd42,       32'd9,        1'b1};
    tbl[8] = '{1'b1, 32'd1,  1'b1, 32'd1,  4'd6, 4'hF, 8'h00, 1'b1, 4'd6, 32'd77, 1'b1, 32'd1,        32'd1,        1'b1};

    // Reset
    rst = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 0;

    // Table vectors
    for (int k = 0; k < 9; k++) begin
      drive(1, tbl[k].i1, tbl[k].o1, tbl[k].i2, tbl[k].o2, tbl[k].dest, tbl[k].fsel,
            tbl[k].flg, tbl[k].wv, tbl[k].wa, tbl[k].wd, 1'b1);
      #1;
      chk($sformatf("tbl%0d_ready", k), {31'd0, in_ready}, {31'd0, tbl[k].e_rdy});
      step();
      chk($sformatf("tbl%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("tbl%0d_a", k), out_a, tbl[k].e_a);
      chk($sformatf("tbl%0d_b", k), out_b, tbl[k].e_b);
      chk($sformatf("tbl%0d_dest", k), {28'd0, out_dest}, {28'd0, tbl[k].dest});
      chk($sformatf("tbl%0d_cond", k), {31'd0, out_cond}, {31'd0, tbl[k].e_cond});
    end

    // Hazard stall on r3, released by a forwarded writeback
    drive(1, 1, 32'd1, 1, 32'd1, 4'd3, 4'hF, 8'h00, 0, 0, 0, 1);
    step();
    chk("busy3_set", {31'd0, dut.r_busy[3]}, 32'd1);
    drive(1, 0, 32'd3, 1, 32'd0, 4'd12, 4'hF, 8'h00, 0, 0, 0, 1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    chk("stall_cnt3", {16'd0, stall_cnt}, 32'd3);
    rf[3] = 32'h333;
    drive(1, 0, 32'd3, 1, 32'd0, 4'd12, 4'hF, 8'h00, 1, 4'd3, 32'd42, 1);
    step();
    chk("fwd_a", out_a, 32'd42);
    chk("fwd_valid", {31'd0, out_valid}, 32'd1);
    chk("fwd_stall_hold", {16'd0, stall_cnt}, 32'd3);

    // Backpressure: hold for 3 cycles, then back-to-back transfers
    drive(1, 1, 32'h11, 1, 32'h22, 4'd13, 4'd14, 8'hFF, 0, 0, 0, 1);
    step();
    drive(1, 1, 32'h33, 1, 32'h44, 4'd13, 4'd14, 8'hFF, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("hold_a", out_a, 32'h11);
      chk("hold_b", out_b, 32'h22);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1;
    step();
    chk("b2b1_a", out_a, 32'h33);
    chk("b2b1_valid", {31'd0, out_valid}, 32'd1);
    drive(1, 1, 32'h55, 1, 32'h66, 4'd13, 4'd14, 8'hFF, 0, 0, 0, 1);
    step();
    chk("b2b2_a", out_a, 32'h55);
    chk("b2b2_valid", {31'd0, out_valid}, 32'd1);

    // Same-cycle set and clear on r5: set wins
    drive(1, 1, 32'd0, 1, 32'd0, 4'd5, 4'hF, 8'h00, 1, 4'd5, 32'd9, 1);
    step();
    chk("busy5_setwins", {31'd0, dut.r_busy[5]}, 32'd1);

    // Stall on r5, then reset mid-stall
    drive(1, 0, 32'd5, 1, 32'd0, 4'd14, 4'hF, 8'h00, 0, 0, 0, 1);
    step();
    step();
    chk("stall_cnt5", {16'd0, stall_cnt}, 32'd5);
    rst = 1;
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    step();
    rst = 0;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {16'd0, dut.r_busy}, 32'd0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(99) == 0);
      drive($urandom_range(9) < 7, 1'($urandom), $urandom, 1'($urandom), $urandom,
            4'($urandom), 4'($urandom), 8'($urandom), $urandom_range(9) < 4,
            4'($urandom), $urandom, $urandom_range(9) < 7);
      step();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
